// File: rtl/nova_io_pkg.sv
// Shared Nova I/O encodings: transfer/function/skip codes, register selects, FSM states.
// Nova numbers bit 0 as the MSB; vectors here are [15:0], so Nova bit n sits at index 15-n.
package nova_io_pkg;

  typedef enum logic [2:0] {
    XF_NIO = 3'b000,
    XF_DIA = 3'b001,
    XF_DOA = 3'b010,
    XF_DIB = 3'b011,
    XF_DOB = 3'b100,
    XF_DIC = 3'b101,
    XF_DOC = 3'b110,
    XF_SKP = 3'b111
  } xfer_e;

  typedef enum logic [1:0] {
    REG_CTRL = 2'b00,
    REG_A    = 2'b01,
    REG_B    = 2'b10,
    REG_C    = 2'b11
  } reg_e;

  typedef enum logic [1:0] {
    FN_NONE = 2'b00,
    FN_S    = 2'b01,
    FN_C    = 2'b10,
    FN_P    = 2'b11
  } func_e;

  typedef enum logic [1:0] {
    SK_BN = 2'b00,
    SK_BZ = 2'b01,
    SK_DN = 2'b10,
    SK_DZ = 2'b11
  } skip_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA,
    ST_GAP,
    ST_CTRL,
    ST_FLAG,
    ST_DONE
  } state_e;

  localparam logic [2:0] IO_OPCODE = 3'b011;

  // Flag positions in Nova numbering, and their index in a [15:0] vector.
  localparam int FLAG_BUSY    = 0;
  localparam int FLAG_DONE    = 1;
  localparam int DIN_BUSY_IDX = 15 - FLAG_BUSY;
  localparam int DIN_DONE_IDX = 15 - FLAG_DONE;

  function automatic reg_e xfer_reg(input xfer_e x);
    case (x)
      XF_DIA, XF_DOA: xfer_reg = REG_A;
      XF_DIB, XF_DOB: xfer_reg = REG_B;
      XF_DIC, XF_DOC: xfer_reg = REG_C;
      default:        xfer_reg = REG_CTRL;
    endcase
  endfunction

  function automatic logic xfer_is_write(input xfer_e x);
    xfer_is_write = (x == XF_DOA) || (x == XF_DOB) || (x == XF_DOC);
  endfunction

  function automatic logic skip_eval(input logic [1:0] cond, input logic busy, input logic done);
    case (skip_e'(cond))
      SK_BN:   skip_eval = busy;
      SK_BZ:   skip_eval = ~busy;
      SK_DN:   skip_eval = done;
      default: skip_eval = ~done;
    endcase
  endfunction

  function automatic logic [15:0] ctrl_word(input logic [1:0] func);
    ctrl_word = {14'h0, func};
  endfunction

endpackage

// File: rtl/nova_io_pio_master_if.sv
// CPU request/ack handshake and PIO device bus, bundled for the PIO master.
// master = sequencer view, slave = CPU plus device side.
interface nova_io_pio_master_if;
  logic        cpu_req;
  logic [15:0] cpu_ir;
  logic [15:0] cpu_acc;
  logic        cpu_ack;
  logic [15:0] cpu_data;
  logic        cpu_skip;
  logic        cpu_ill;
  logic        bs_stb;
  logic        bs_we;
  logic [7:0]  bs_adr;
  logic [15:0] bs_dout;
  logic [15:0] bs_din;

  modport master (
    input  cpu_req, cpu_ir, cpu_acc, bs_din,
    output cpu_ack, cpu_data, cpu_skip, cpu_ill, bs_stb, bs_we, bs_adr, bs_dout
  );

  modport slave (
    output cpu_req, cpu_ir, cpu_acc, bs_din,
    input  cpu_ack, cpu_data, cpu_skip, cpu_ill, bs_stb, bs_we, bs_adr, bs_dout
  );
endinterface

// File: rtl/nova_io_pio_master.sv
// Runs one Nova I/O instruction as data/control/flag strobes on the PIO bus; DOx+func acks 3+GAP_CYC cycles after accept.
// CPU holds cpu_req until the one-cycle cpu_ack; the bus has no backpressure (devices answer in the strobe cycle).
module nova_io_pio_master
  import nova_io_pkg::*;
#(
  parameter int GAP_CYC       = 1,
  parameter bit EMIT_SPURIOUS = 1'b1
) (
  input  logic                        pclk,
  input  logic                        prst,
  nova_io_pio_master_if.master        io
);

  localparam logic [2:0] GAP_LAST = 3'(GAP_CYC - 1);

  state_e      r_state;
  xfer_e       r_xfer;
  logic [1:0]  r_func;
  logic [5:0]  r_dev;
  logic [2:0]  r_gap_cnt;
  logic        r_stb;
  logic        r_we;
  logic [7:0]  r_adr;
  logic [15:0] r_dout;
  logic        r_ack;
  logic        r_skip;
  logic        r_ill;
  logic [15:0] r_data;

  xfer_e       w_xfer;
  logic [1:0]  w_func;
  logic [5:0]  w_dev;
  logic        w_legal;
  logic        w_unused_ac;

  assign w_xfer  = xfer_e'(io.cpu_ir[10:8]);
  assign w_func  = io.cpu_ir[7:6];
  assign w_dev   = io.cpu_ir[5:0];
  assign w_legal = (io.cpu_ir[15:13] == IO_OPCODE);
  // Accumulator select belongs to the CPU; the value arrives on cpu_acc.
  assign w_unused_ac = ^io.cpu_ir[12:11];

  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      r_state   <= ST_IDLE;
      r_xfer    <= XF_NIO;
      r_func    <= 2'b00;
      r_dev     <= 6'd0;
      r_gap_cnt <= 3'd0;
      r_stb     <= 1'b0;
      r_we      <= 1'b0;
      r_adr     <= 8'd0;
      r_dout    <= 16'd0;
      r_ack     <= 1'b0;
      r_skip    <= 1'b0;
      r_ill     <= 1'b0;
      r_data    <= 16'd0;
    end else begin
      r_stb  <= 1'b0;
      r_ack  <= 1'b0;
      r_skip <= 1'b0;
      r_ill  <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (io.cpu_req) begin
            r_xfer <= w_xfer;
            r_func <= w_func;
            r_dev  <= w_dev;
            if (!w_legal) begin
              r_state <= ST_DONE;
              r_ack   <= 1'b1;
              r_ill   <= 1'b1;
            end else begin
              case (w_xfer)
                XF_SKP: begin
                  r_state <= ST_FLAG;
                  r_stb   <= 1'b1;
                  r_we    <= 1'b0;
                  r_adr   <= {w_dev, REG_CTRL};
                end
                XF_NIO: begin
                  if (w_func == FN_NONE && !EMIT_SPURIOUS) begin
                    r_state <= ST_DONE;
                    r_ack   <= 1'b1;
                  end else begin
                    r_state <= ST_CTRL;
                    r_stb   <= 1'b1;
                    r_we    <= 1'b1;
                    r_adr   <= {w_dev, REG_CTRL};
                    r_dout  <= ctrl_word(w_func);
                  end
                end
                default: begin
                  r_state <= ST_DATA;
                  r_stb   <= 1'b1;
                  r_we    <= xfer_is_write(w_xfer);
                  r_adr   <= {w_dev, xfer_reg(w_xfer)};
                  if (xfer_is_write(w_xfer)) begin
                    r_dout <= io.cpu_acc;
                  end
                end
              endcase
            end
          end
        end

        ST_DATA: begin
          if (!xfer_is_write(r_xfer)) begin
            r_data <= io.bs_din;
          end
          if (r_func != FN_NONE) begin
            if (GAP_CYC > 0) begin
              r_state   <= ST_GAP;
              r_gap_cnt <= 3'd0;
            end else begin
              r_state <= ST_CTRL;
              r_stb   <= 1'b1;
              r_we    <= 1'b1;
              r_adr   <= {r_dev, REG_CTRL};
              r_dout  <= ctrl_word(r_func);
            end
          end else begin
            r_state <= ST_DONE;
            r_ack   <= 1'b1;
          end
        end

        ST_GAP: begin
          if (r_gap_cnt == GAP_LAST) begin
            r_state <= ST_CTRL;
            r_stb   <= 1'b1;
            r_we    <= 1'b1;
            r_adr   <= {r_dev, REG_CTRL};
            r_dout  <= ctrl_word(r_func);
          end else begin
            r_gap_cnt <= r_gap_cnt + 3'd1;
          end
        end

        ST_CTRL: begin
          r_state <= ST_DONE;
          r_ack   <= 1'b1;
        end

        ST_FLAG: begin
          r_state <= ST_DONE;
          r_ack   <= 1'b1;
          r_skip  <= skip_eval(r_func, io.bs_din[DIN_BUSY_IDX], io.bs_din[DIN_DONE_IDX]);
        end

        // ST_DONE: ack is on the bus this cycle; a still-high cpu_req waits for IDLE.
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign io.cpu_ack  = r_ack;
  assign io.cpu_data = r_data;
  assign io.cpu_skip = r_skip;
  assign io.cpu_ill  = r_ill;
  assign io.bs_stb   = r_stb;
  assign io.bs_we    = r_we;
  assign io.bs_adr   = r_adr;
  assign io.bs_dout  = r_dout;

endmodule

// File: tb/tb_nova_io_pio_master.sv
// Bench for nova_io_pio_master: two instances (GAP 1/spurious on, GAP 0/spurious off), vector table
// with strobe and result scoreboards, plus a hand-written reset-in-GAP sequence.
module tb_nova_io_pio_master;
  import nova_io_pkg::*;

  localparam int GAP0 = 1;
  localparam int GAP1 = 0;

  logic        pclk = 1'b0;
  logic        prst = 1'b1;
  logic        req  = 1'b0;
  logic [15:0] ir   = 16'h0;
  logic [15:0] acc  = 16'h0;
  logic [15:0] din  = 16'h0;
  int          sel  = 0;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 pclk = ~pclk;

  nova_io_pio_master_if bus0 ();
  nova_io_pio_master_if bus1 ();

  assign bus0.cpu_req = req && (sel == 0);
  assign bus0.cpu_ir  = ir;
  assign bus0.cpu_acc = acc;
  assign bus0.bs_din  = din;
  assign bus1.cpu_req = req && (sel == 1);
  assign bus1.cpu_ir  = ir;
  assign bus1.cpu_acc = acc;
  assign bus1.bs_din  = din;

  nova_io_pio_master #(.GAP_CYC(GAP0), .EMIT_SPURIOUS(1'b1)) u_dut0 (.pclk(pclk), .prst(prst), .io(bus0));
  nova_io_pio_master #(.GAP_CYC(GAP1), .EMIT_SPURIOUS(1'b0)) u_dut1 (.pclk(pclk), .prst(prst), .io(bus1));

  logic        m_stb, m_we, m_ack, m_skip, m_ill;
  logic [7:0]  m_adr;
  logic [15:0] m_dout, m_data;
  assign m_stb  = (sel == 0) ? bus0.bs_stb   : bus1.bs_stb;
  assign m_we   = (sel == 0) ? bus0.bs_we    : bus1.bs_we;
  assign m_adr  = (sel == 0) ? bus0.bs_adr   : bus1.bs_adr;
  assign m_dout = (sel == 0) ? bus0.bs_dout  : bus1.bs_dout;
  assign m_ack  = (sel == 0) ? bus0.cpu_ack  : bus1.cpu_ack;
  assign m_skip = (sel == 0) ? bus0.cpu_skip : bus1.cpu_skip;
  assign m_ill  = (sel == 0) ? bus0.cpu_ill  : bus1.cpu_ill;
  assign m_data = (sel == 0) ? bus0.cpu_data : bus1.cpu_data;

  typedef struct {
    int          which;
    logic [2:0]  op;
    logic [2:0]  xfer;
    logic [1:0]  func;
    logic [5:0]  dev;
    logic [15:0] acc;
    logic [15:0] din;
    int          ack_cyc;
    logic        skip;
    logic        ill;
    logic [15:0] data;
  } vec_t;

  typedef struct {
    int          cyc;
    logic        we;
    logic [7:0]  adr;
    logic [15:0] dout;
    bit          chk_dout;
  } exp_stb_t;

  typedef struct {
    int          cyc;
    logic        skip;
    logic        ill;
    logic [15:0] data;
  } exp_res_t;

  exp_stb_t stb_q[$];
  exp_res_t res_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got event expected none/other", nm);
  endtask

  function automatic vec_t mkv(input int which, input logic [2:0] op, input logic [2:0] xfer,
                               input logic [1:0] func, input logic [5:0] dev, input logic [15:0] a,
                               input logic [15:0] d, input int ack_cyc, input logic skip,
                               input logic ill, input logic [15:0] data);
    vec_t v;
    v.which = which; v.op = op; v.xfer = xfer; v.func = func; v.dev = dev; v.acc = a;
    v.din = d; v.ack_cyc = ack_cyc; v.skip = skip; v.ill = ill; v.data = data;
    return v;
  endfunction

  task automatic push_stb(input int cyc, input logic we, input logic [7:0] adr,
                          input logic [15:0] dout, input bit chkd);
    exp_stb_t s;
    s.cyc = cyc; s.we = we; s.adr = adr; s.dout = dout; s.chk_dout = chkd;
    stb_q.push_back(s);
  endtask

  // Expected bus activity derived from the instruction fields alone.
  task automatic model_strobes(input vec_t v);
    int   gap;
    bit   es;
    bit   wr;
    int   rg;
    gap = (v.which == 0) ? GAP0 : GAP1;
    es  = (v.which == 0);
    if (v.op == 3'b011) begin
      if (v.xfer == 3'b000) begin
        if (v.func != 2'b00 || es) push_stb(1, 1'b1, {v.dev, 2'b00}, {14'h0, v.func}, 1'b1);
      end else if (v.xfer == 3'b111) begin
        push_stb(1, 1'b0, {v.dev, 2'b00}, 16'h0, 1'b0);
      end else begin
        wr = ~v.xfer[0];
        rg = (int'(v.xfer) + 1) / 2;
        push_stb(1, wr, {v.dev, rg[1:0]}, v.acc, wr);
        if (v.func != 2'b00) push_stb(2 + gap, 1'b1, {v.dev, 2'b00}, {14'h0, v.func}, 1'b1);
      end
    end
  endtask

  task automatic run(input vec_t v, input string tag);
    exp_stb_t s;
    exp_res_t r;
    bit       acked;
    int       post;
    sel = v.which;
    ir  = {v.op, 2'b00, v.xfer, v.func, v.dev};
    acc = v.acc;
    din = v.din;
    model_strobes(v);
    r.cyc = v.ack_cyc; r.skip = v.skip; r.ill = v.ill; r.data = v.data;
    res_q.push_back(r);
    @(negedge pclk);
    req   = 1'b1;
    acked = 1'b0;
    post  = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge pclk);
      if (m_stb) begin
        if (stb_q.size() == 0) begin
          fail_now({tag, "/unexpected_stb"});
        end else begin
          s = stb_q.pop_front();
          chk({tag, "/stb_cyc"}, c, s.cyc);
          chk({tag, "/stb_we"}, {31'd0, m_we}, {31'd0, s.we});
          chk({tag, "/stb_adr"}, {24'd0, m_adr}, {24'd0, s.adr});
          if (s.chk_dout) chk({tag, "/stb_dout"}, {16'd0, m_dout}, {16'd0, s.dout});
        end
      end
      if (acked) begin
        post++;
        if (post == 1) chk({tag, "/ack_pulse"}, {31'd0, m_ack}, 32'd0);
        if (post >= 3) break;
      end else if (m_ack) begin
        r = res_q.pop_front();
        chk({tag, "/ack_cyc"}, c, r.cyc);
        chk({tag, "/skip"}, {31'd0, m_skip}, {31'd0, r.skip});
        chk({tag, "/ill"}, {31'd0, m_ill}, {31'd0, r.ill});
        chk({tag, "/data"}, {16'd0, m_data}, {16'd0, r.data});
        acked = 1'b1;
        req   = 1'b0;
      end
    end
    if (!acked) begin
      fail_now({tag, "/ack_timeout"});
      req = 1'b0;
      res_q.delete();
    end
    while (stb_q.size() > 0) begin
      s = stb_q.pop_front();
      fail_now({tag, "/missing_stb"});
    end
  endtask

  vec_t vecs[16];

  initial begin
    int bad;
    //            dut op      xfer    func   dev    acc      din      ack sk ill data
    vecs[0]  = mkv(0, 3'b011, XF_DOA, 2'b01, 6'o12, 16'h1234, 16'h0000, 4, 0, 0, 16'h0000);
    vecs[1]  = mkv(0, 3'b011, XF_DIB, 2'b00, 6'o33, 16'h0000, 16'hBEEF, 2, 0, 0, 16'hBEEF);
    vecs[2]  = mkv(0, 3'b011, XF_SKP, 2'b10, 6'o10, 16'h0000, 16'h4000, 2, 1, 0, 16'hBEEF);
    vecs[3]  = mkv(0, 3'b011, XF_SKP, 2'b10, 6'o10, 16'h0000, 16'h0000, 2, 0, 0, 16'hBEEF);
    vecs[4]  = mkv(0, 3'b011, XF_SKP, 2'b01, 6'o10, 16'h0000, 16'h8000, 2, 0, 0, 16'hBEEF);
    vecs[5]  = mkv(0, 3'b011, XF_SKP, 2'b00, 6'o10, 16'h0000, 16'h8000, 2, 1, 0, 16'hBEEF);
    vecs[6]  = mkv(0, 3'b011, XF_SKP, 2'b11, 6'o10, 16'h0000, 16'h8000, 2, 1, 0, 16'hBEEF);
    vecs[7]  = mkv(0, 3'b011, XF_NIO, 2'b00, 6'o05, 16'hFFFF, 16'h0000, 2, 0, 0, 16'hBEEF);
    vecs[8]  = mkv(0, 3'b011, XF_NIO, 2'b10, 6'o77, 16'h0000, 16'h0000, 2, 0, 0, 16'hBEEF);
    vecs[9]  = mkv(0, 3'b000, XF_DOA, 2'b01, 6'o12, 16'hFFFF, 16'h0000, 1, 0, 1, 16'hBEEF);
    vecs[10] = mkv(0, 3'b011, XF_DIC, 2'b11, 6'o77, 16'h0000, 16'h55AA, 4, 0, 0, 16'h55AA);
    vecs[11] = mkv(0, 3'b011, XF_DOC, 2'b00, 6'o03, 16'h0F0F, 16'h0000, 2, 0, 0, 16'h55AA);
    vecs[12] = mkv(1, 3'b011, XF_NIO, 2'b00, 6'o05, 16'h0000, 16'h0000, 1, 0, 0, 16'h0000);
    vecs[13] = mkv(1, 3'b011, XF_DOB, 2'b01, 6'o01, 16'hA5A5, 16'h0000, 3, 0, 0, 16'h0000);
    vecs[14] = mkv(1, 3'b111, XF_DIA, 2'b00, 6'o02, 16'h0000, 16'h1111, 1, 0, 1, 16'h0000);
    vecs[15] = mkv(1, 3'b011, XF_DIA, 2'b10, 6'o02, 16'h0000, 16'h1357, 3, 0, 0, 16'h1357);

    #12;
    chk("rst/stb",  {31'd0, bus0.bs_stb},  32'd0);
    chk("rst/we",   {31'd0, bus0.bs_we},   32'd0);
    chk("rst/ack",  {31'd0, bus0.cpu_ack}, 32'd0);
    chk("rst/skip", {31'd0, bus0.cpu_skip}, 32'd0);
    chk("rst/ill",  {31'd0, bus0.cpu_ill}, 32'd0);
    chk("rst/adr",  {24'd0, bus0.bs_adr},  32'd0);
    chk("rst/dout", {16'd0, bus0.bs_dout}, 32'd0);
    chk("rst/data", {16'd0, bus0.cpu_data}, 32'd0);
    chk("rst/stb1", {31'd0, bus1.bs_stb},  32'd0);
    @(negedge pclk);
    prst = 1'b0;
    repeat (2) @(negedge pclk);

    for (int i = 0; i < 16; i++) run(vecs[i], $sformatf("v%0d", i));

    // Reset while a DOC+P sits in its gap cycle.
    sel = 0;
    ir  = {3'b011, 2'b00, XF_DOC, 2'b11, 6'o21};
    acc = 16'hCAFE;
    @(negedge pclk);
    req = 1'b1;
    @(negedge pclk);
    chk("rstmid/data_stb", {31'd0, m_stb}, 32'd1);
    chk("rstmid/data_dout", {16'd0, m_dout}, 32'h0000CAFE);
    @(posedge pclk);
    #2 prst = 1'b1;
    #1;
    chk("rstmid/stb",  {31'd0, m_stb},  32'd0);
    chk("rstmid/we",   {31'd0, m_we},   32'd0);
    chk("rstmid/adr",  {24'd0, m_adr},  32'd0);
    chk("rstmid/dout", {16'd0, m_dout}, 32'd0);
    chk("rstmid/data", {16'd0, m_data}, 32'd0);
    req = 1'b0;
    bad = 0;
    for (int c = 0; c < 7; c++) begin
      @(negedge pclk);
      if (c == 2) prst = 1'b0;
      if (m_stb || m_ack) bad++;
    end
    chk("rstmid/no_bus_after", bad, 0);

    run(mkv(0, 3'b011, XF_DIA, 2'b00, 6'o02, 16'h0000, 16'h0F0F, 2, 0, 0, 16'h0F0F), "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog expired");
  end

endmodule
